crossbar_out_port_ctrl: RTL and testbench

Output-port controller for the crossbar. It sits on the requester side of the round-robin arbiter. It snapshots which input channels hold a packet for this output and issues a one-cycle request vector to the arbiter. It consumes the registered one-hot grant, then switches the granted channel's stream through a registered output stage until the packet's last beat, and re-arbitrates only at packet boundaries.

---
 rtl/crossbar_out_port_ctrl_pkg.sv | 24 ++
 rtl/crossbar_out_reg_slice.sv | 60 ++++++
 rtl/crossbar_out_port_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_crossbar_out_port_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_out_port_ctrl_pkg.sv
// Shared crossbar definitions: FSM encodings, grant timeout and a one-hot helper.
package crossbar_out_port_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_GNT = 2'd2,
        ST_XFER     = 2'd3
    } xbar_state_e;

    // Cycles spent in WAIT_GNT before the request is abandoned (fits the 4-bit counter).
    localparam int P_GNT_TIMEOUT = 15;

    // Widest vector the one-hot helper accepts; callers zero-extend to this width.
    localparam int ONEHOT_MAX_W = 32;

    // True when exactly one bit of vec is set.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
        logic [ONEHOT_MAX_W-1:0] one;
        one = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1};
        return (vec != '0) && ((vec & (vec - one)) == '0);
    endfunction

endpackage

// File: rtl/crossbar_out_reg_slice.sv
// Single-entry valid/ready output register carrying data, keep and last.
module crossbar_out_reg_slice #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [P_DATA_WIDTH-1:0] i_data,
    input  logic [P_KEEP_WIDTH-1:0] i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic [P_KEEP_WIDTH-1:0] o_keep,
    output logic                    o_last
);

    logic                    valid_q, valid_d;
    logic [P_DATA_WIDTH-1:0] data_q,  data_d;
    logic [P_KEEP_WIDTH-1:0] keep_q,  keep_d;
    logic                    last_q,  last_d;

    // Load wins over drain; the payload only changes on a load so it holds under stall.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            keep_d  = i_keep;
            last_d  = i_last;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset drops any held beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_keep  = keep_q;
    assign o_last  = last_q;

endmodule

// File: rtl/crossbar_out_port_ctrl.sv
// Output-port controller: snapshots requesting channels, arbitrates once per
// packet, then streams the granted channel through a registered output stage.
module crossbar_out_port_ctrl
    import crossbar_out_port_ctrl_pkg::*;
#(
    parameter int P_CHANNEL_NUM = 4,
    parameter int P_DATA_WIDTH  = 64,
    parameter int P_KEEP_WIDTH  = P_DATA_WIDTH / 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [P_CHANNEL_NUM-1:0]              i_ch_valid,
    input  logic [P_CHANNEL_NUM*P_DATA_WIDTH-1:0] i_ch_data,
    input  logic [P_CHANNEL_NUM*P_KEEP_WIDTH-1:0] i_ch_keep,
    input  logic [P_CHANNEL_NUM-1:0]              i_ch_last,
    output logic [P_CHANNEL_NUM-1:0]              o_ch_ready,
    output logic [P_CHANNEL_NUM-1:0]              o_arb_req,
    output logic                                  o_arb_req_valid,
    input  logic [P_CHANNEL_NUM-1:0]              i_arb_grant,
    input  logic                                  i_arb_grant_valid,
    output logic                                  o_arb_reset_priority,
    input  logic                                  i_prio_clr,
    output logic                                  o_out_valid,
    output logic [P_DATA_WIDTH-1:0]               o_out_data,
    output logic [P_KEEP_WIDTH-1:0]               o_out_keep,
    output logic                                  o_out_last,
    input  logic                                  i_out_ready,
    output logic                                  o_busy,
    output logic                                  o_err_gnt
);

    xbar_state_e              state_q, state_d;
    logic [P_CHANNEL_NUM-1:0] req_q,   req_d;
    logic [P_CHANNEL_NUM-1:0] sel_q,   sel_d;
    logic [3:0]               cnt_q,   cnt_d;
    logic                     prio_q;

    logic                     grant_good;
    logic                     timeout_hit;
    logic                     slot_free;
    logic [P_CHANNEL_NUM-1:0] ch_ready;
    logic                     accept;
    logic [P_DATA_WIDTH-1:0]  mux_data;
    logic [P_KEEP_WIDTH-1:0]  mux_keep;
    logic                     mux_last;

    logic [P_DATA_WIDTH-1:0]  ch_data_masked [P_CHANNEL_NUM];
    logic [P_KEEP_WIDTH-1:0]  ch_keep_masked [P_CHANNEL_NUM];

    // A grant is usable only if it names exactly one channel we actually asked for.
    assign grant_good  = is_onehot(ONEHOT_MAX_W'(i_arb_grant)) &&
                         ((i_arb_grant & req_q) == i_arb_grant);
    assign timeout_hit = (cnt_q == 4'(P_GNT_TIMEOUT));
    assign slot_free   = !o_out_valid || i_out_ready;
    assign accept      = |(i_ch_valid & ch_ready);

    // Per-channel masking by the one-hot selection, OR-reduced below.
    generate
        for (genvar gi = 0; gi < P_CHANNEL_NUM; gi++) begin : g_mux
            assign ch_data_masked[gi] = sel_q[gi] ? i_ch_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH] : '0;
            assign ch_keep_masked[gi] = sel_q[gi] ? i_ch_keep[gi*P_KEEP_WIDTH +: P_KEEP_WIDTH] : '0;
        end
    endgenerate

    // One-hot AND-OR mux of the selected channel's payload.
    always_comb begin
        mux_data = '0;
        mux_keep = '0;
        for (int k = 0; k < P_CHANNEL_NUM; k++) begin
            mux_data = mux_data | ch_data_masked[k];
            mux_keep = mux_keep | ch_keep_masked[k];
        end
    end
    assign mux_last = |(i_ch_last & sel_q);

    // FSM state register with the request snapshot, selection and grant timer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a grant arriving together with the timeout still wins.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|i_ch_valid) begin
                    req_d   = i_ch_valid;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                cnt_d = cnt_q + 4'd1;
                if (i_arb_grant_valid) begin
                    if (grant_good) begin
                        sel_d   = i_arb_grant;
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (accept && mux_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore/Mealy outputs decoded from the current state.
    always_comb begin
        o_arb_req       = '0;
        o_arb_req_valid = 1'b0;
        ch_ready        = '0;
        o_err_gnt       = 1'b0;
        o_busy          = (state_q != ST_IDLE);
        unique case (state_q)
            ST_REQ: begin
                o_arb_req       = req_q;
                o_arb_req_valid = 1'b1;
            end
            ST_WAIT_GNT: begin
                o_arb_req = req_q;
                o_err_gnt = i_arb_grant_valid ? !grant_good : timeout_hit;
            end
            ST_XFER: begin
                ch_ready = slot_free ? sel_q : '0;
            end
            default: ;
        endcase
    end
    assign o_ch_ready = ch_ready;

    // Priority-clear request to the arbiter, delayed one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= i_prio_clr;
        end
    end
    assign o_arb_reset_priority = prio_q;

    crossbar_out_reg_slice #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_KEEP_WIDTH (P_KEEP_WIDTH)
    ) u_out_slice (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_data  (mux_data),
        .i_keep  (mux_keep),
        .i_last  (mux_last),
        .i_ready (i_out_ready),
        .o_valid (o_out_valid),
        .o_data  (o_out_data),
        .o_keep  (o_out_keep),
        .o_last  (o_out_last)
    );

endmodule

// File: tb/tb_crossbar_out_port_ctrl.sv
// Scoreboard bench for crossbar_out_port_ctrl with a round-robin arbiter model.
module tb_crossbar_out_port_ctrl;

    localparam int N = 4;
    localparam int W = 64;
    localparam int K = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   i_ch_valid;
    logic [N*W-1:0] i_ch_data;
    logic [N*K-1:0] i_ch_keep;
    logic [N-1:0]   i_ch_last;
    logic [N-1:0]   o_ch_ready;
    logic [N-1:0]   o_arb_req;
    logic           o_arb_req_valid;
    logic [N-1:0]   i_arb_grant;
    logic           i_arb_grant_valid;
    logic           o_arb_reset_priority;
    logic           i_prio_clr;
    logic           o_out_valid;
    logic [W-1:0]   o_out_data;
    logic [K-1:0]   o_out_keep;
    logic           o_out_last;
    logic           i_out_ready;
    logic           o_busy;
    logic           o_err_gnt;

    crossbar_out_port_ctrl #(
        .P_CHANNEL_NUM (N),
        .P_DATA_WIDTH  (W),
        .P_KEEP_WIDTH  (K)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_ch_valid           (i_ch_valid),
        .i_ch_data            (i_ch_data),
        .i_ch_keep            (i_ch_keep),
        .i_ch_last            (i_ch_last),
        .o_ch_ready           (o_ch_ready),
        .o_arb_req            (o_arb_req),
        .o_arb_req_valid      (o_arb_req_valid),
        .i_arb_grant          (i_arb_grant),
        .i_arb_grant_valid    (i_arb_grant_valid),
        .o_arb_reset_priority (o_arb_reset_priority),
        .i_prio_clr           (i_prio_clr),
        .o_out_valid          (o_out_valid),
        .o_out_data           (o_out_data),
        .o_out_keep           (o_out_keep),
        .o_out_last           (o_out_last),
        .i_out_ready          (i_out_ready),
        .o_busy               (o_busy),
        .o_err_gnt            (o_err_gnt)
    );

    always #5 clk = ~clk;

    beat_t       sb_q[$];
    beat_t       mem [N][64];
    int          wr [N];
    int          rd [N];
    int          n_chk = 0;
    int          n_fail = 0;
    int          req_pulses = 0;
    int          arb_mode = 0;      // 0 round-robin, 1 forced grant, 2 never grant
    logic [N-1:0] arb_force = '0;
    int          rr_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int ch, input int pid, input int b, input int nb);
        beat_t x;
        x.data = {4'hC, 4'(ch), 8'(pid), 16'hBEEF, 24'h0, 8'(b)};
        x.last = (b == nb - 1);
        x.keep = x.last ? 8'h0F : 8'hFF;
        return x;
    endfunction

    // Queue a packet on a channel source and its expected beats on the scoreboard.
    task automatic add_pkt(input int ch, input int pid, input int nb);
        for (int b = 0; b < nb; b++) begin
            mem[ch][wr[ch]] = mk_beat(ch, pid, b, nb);
            wr[ch]++;
            sb_q.push_back(mk_beat(ch, pid, b, nb));
        end
    endtask

    function automatic logic src_empty();
        for (int k = 0; k < N; k++) if (rd[k] < wr[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_busy && src_empty()) done = 1'b1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending beats, busy %0d, expected 0 and 0", name, sb_q.size(), o_busy);
        end
    endtask

    task automatic wait_out_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (o_out_valid) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_wait: got no output beat, expected one within 30 cycles", name);
        end
    endtask

    // Channel sources: present the head beat, advance on a handshake.
    initial begin : src_drv
        logic [N-1:0] hs;
        i_ch_valid = '0;
        i_ch_data  = '0;
        i_ch_keep  = '0;
        i_ch_last  = '0;
        forever begin
            @(negedge clk);
            hs = i_ch_valid & o_ch_ready;
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if (hs[k] && rd[k] < wr[k]) rd[k]++;
                if (rd[k] < wr[k]) begin
                    i_ch_valid[k]       = 1'b1;
                    i_ch_data[k*W +: W] = mem[k][rd[k]].data;
                    i_ch_keep[k*K +: K] = mem[k][rd[k]].keep;
                    i_ch_last[k]        = mem[k][rd[k]].last;
                end else begin
                    i_ch_valid[k]       = 1'b0;
                    i_ch_data[k*W +: W] = '0;
                    i_ch_keep[k*K +: K] = '0;
                    i_ch_last[k]        = 1'b0;
                end
            end
        end
    end

    // Arbiter model: registered grant one cycle after the request strobe.
    initial begin : arb_model
        logic         pend;
        logic [N-1:0] r;
        logic [N-1:0] g;
        int           idx;
        i_arb_grant       = '0;
        i_arb_grant_valid = 1'b0;
        forever begin
            @(negedge clk);
            pend = o_arb_req_valid;
            r    = o_arb_req;
            if (o_arb_reset_priority) rr_ptr = 0;
            @(posedge clk);
            #1;
            if (!rst && pend && arb_mode != 2) begin
                if (arb_mode == 1) begin
                    g = arb_force;
                end else begin
                    g = '0;
                    for (int i = 0; i < N; i++) begin
                        idx = (rr_ptr + i) % N;
                        if (g == '0 && r[idx]) begin
                            g[idx] = 1'b1;
                            rr_ptr = (idx + 1) % N;
                        end
                    end
                end
                i_arb_grant       = g;
                i_arb_grant_valid = 1'b1;
            end else begin
                i_arb_grant       = '0;
                i_arb_grant_valid = 1'b0;
            end
        end
    end

    // Monitor: every accepted output beat is compared with the scoreboard head.
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (o_arb_req_valid) req_pulses++;
            if (o_out_valid && i_out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_beat: got unexpected beat %h, expected none", o_out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", o_out_data, e.data);
                    check("out_keep", 64'(o_out_keep), 64'(e.keep));
                    check("out_last", 64'(o_out_last), 64'(e.last));
                    $display("beat data=%h keep=%h last=%0d", o_out_data, o_out_keep, o_out_last);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        rst         = 1'b1;
        i_prio_clr  = 1'b0;
        i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      64'(o_busy),               64'd0);
        check("rst_out_valid", 64'(o_out_valid),          64'd0);
        check("rst_req_valid", 64'(o_arb_req_valid),      64'd0);
        check("rst_ch_ready",  64'(o_ch_ready),           64'd0);
        check("rst_err",       64'(o_err_gnt),            64'd0);
        check("rst_prio",      64'(o_arb_reset_priority), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single 3-beat packet on channel 2, cycle-accurate latency.
        @(posedge clk); #1 add_pkt(2, 1, 3);
        @(negedge clk);
        check("t1_c0_busy",      64'(o_busy),          64'd0);
        @(negedge clk);
        check("t1_c1_req",       64'(o_arb_req),       64'h4);
        check("t1_c1_req_valid", 64'(o_arb_req_valid), 64'd1);
        @(negedge clk);
        check("t1_c2_req_hold",  64'(o_arb_req),       64'h4);
        check("t1_c2_req_valid", 64'(o_arb_req_valid), 64'd0);
        check("t1_c2_ch_ready",  64'(o_ch_ready),      64'd0);
        @(negedge clk);
        check("t1_c3_ch_ready",  64'(o_ch_ready),      64'h4);
        check("t1_c3_out_valid", 64'(o_out_valid),     64'd0);
        @(negedge clk);
        check("t1_c4_out_valid", 64'(o_out_valid),     64'd1);
        @(negedge clk);
        check("t1_c5_out_valid", 64'(o_out_valid),     64'd1);
        @(negedge clk);
        check("t1_c6_out_valid", 64'(o_out_valid),     64'd1);
        check("t1_c6_out_last",  64'(o_out_last),      64'd1);
        check("t1_c6_ch_ready",  64'(o_ch_ready),      64'd0);
        @(negedge clk);
        check("t1_c7_busy",      64'(o_busy),          64'd0);
        check("t1_c7_out_valid", 64'(o_out_valid),     64'd0);
        wait_idle("t1");

        // Priority clear shows up one cycle later for exactly one cycle.
        @(posedge clk); #1 i_prio_clr = 1'b1;
        @(negedge clk);
        check("t2_prio_c0", 64'(o_arb_reset_priority), 64'd0);
        @(posedge clk); #1 i_prio_clr = 1'b0;
        @(negedge clk);
        check("t2_prio_c1", 64'(o_arb_reset_priority), 64'd1);
        @(negedge clk);
        check("t2_prio_c2", 64'(o_arb_reset_priority), 64'd0);

        // All four channels: served ch0..ch3, packets contiguous, four requests.
        @(posedge clk); #1;
        base = req_pulses;
        for (int c = 0; c < N; c++) add_pkt(c, 10 + c, 2);
        wait_idle("t3");
        check("t3_req_pulses", 64'(req_pulses - base), 64'd4);

        // Backpressure for 5 cycles mid-packet.
        @(posedge clk); #1 add_pkt(1, 4, 6);
        wait_out_valid("t4");
        @(posedge clk); #1 i_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid",    64'(o_out_valid), 64'd1);
            check("t4_stall_ch_ready", 64'(o_ch_ready),  64'd0);
            if (sb_q.size() > 0) begin
                check("t4_stall_data", o_out_data,        sb_q[0].data);
                check("t4_stall_keep", 64'(o_out_keep),   64'(sb_q[0].keep));
                check("t4_stall_last", 64'(o_out_last),   64'(sb_q[0].last));
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL t4_stall_sb: got empty scoreboard, expected a held beat");
            end
        end
        @(posedge clk); #1 i_out_ready = 1'b1;
        wait_idle("t4");

        // Bad grant: unrequested channel granted.
        @(posedge clk); #1;
        arb_mode  = 1;
        arb_force = 4'b0010;
        add_pkt(0, 5, 2);
        @(negedge clk);
        @(negedge clk);
        check("t5_c1_req",       64'(o_arb_req),       64'h1);
        @(negedge clk);
        check("t5_c2_err",       64'(o_err_gnt),       64'd1);
        @(negedge clk);
        check("t5_c3_err",       64'(o_err_gnt),       64'd0);
        check("t5_c3_busy",      64'(o_busy),          64'd0);
        arb_mode = 0;
        @(negedge clk);
        check("t5_c4_req_valid", 64'(o_arb_req_valid), 64'd1);
        check("t5_c4_req",       64'(o_arb_req),       64'h1);
        wait_idle("t5");

        // Grant timeout: error 15 cycles after entering WAIT_GNT.
        @(posedge clk); #1;
        arb_mode = 2;
        add_pkt(3, 6, 2);
        @(negedge clk);
        @(negedge clk);
        check("t6_c1_req_valid", 64'(o_arb_req_valid), 64'd1);
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            check("t6_wait_err", 64'(o_err_gnt), 64'd0);
        end
        @(negedge clk);
        check("t6_c17_err",      64'(o_err_gnt),       64'd1);
        check("t6_c17_busy",     64'(o_busy),          64'd1);
        arb_mode = 0;
        @(negedge clk);
        check("t6_c18_err",      64'(o_err_gnt),       64'd0);
        check("t6_c18_busy",     64'(o_busy),          64'd0);
        @(negedge clk);
        check("t6_c19_req_valid", 64'(o_arb_req_valid), 64'd1);
        check("t6_c19_req",       64'(o_arb_req),       64'h8);
        wait_idle("t6");

        // Reset in XFER mid-packet, then a fresh packet.
        @(posedge clk); #1 add_pkt(1, 7, 8);
        wait_out_valid("t7");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t7_rst_out_valid", 64'(o_out_valid),          64'd0);
        check("t7_rst_out_data",  o_out_data,                64'd0);
        check("t7_rst_out_last",  64'(o_out_last),           64'd0);
        check("t7_rst_ch_ready",  64'(o_ch_ready),           64'd0);
        check("t7_rst_busy",      64'(o_busy),               64'd0);
        check("t7_rst_req",       64'(o_arb_req),            64'd0);
        check("t7_rst_err",       64'(o_err_gnt),            64'd0);
        sb_q.delete();
        rd[1] = wr[1];
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t7_post_busy",     64'(o_busy),               64'd0);
        @(posedge clk); #1 add_pkt(0, 8, 2);
        wait_idle("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
